// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for inter-stage pipeline buffers: stall vector indices, stop encoding,
// bubble payload and pointer sizing helper.
package pipe_stage_buf_pkg;

  localparam int unsigned STALL_W_DEF = 6;
  localparam int unsigned DATA_W_DEF  = 144;

  localparam int unsigned STAGE_PC  = 0;
  localparam int unsigned STAGE_IF  = 1;
  localparam int unsigned STAGE_ID  = 2;
  localparam int unsigned STAGE_EX  = 3;
  localparam int unsigned STAGE_MEM = 4;
  localparam int unsigned STAGE_WB  = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [DATA_W_DEF-1:0] NOP_PAYLOAD = '0;

  // Pointer width; a single-entry buffer still gets a 1-bit (constant zero) pointer.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with optional elastic FIFO, stall/flush handling,
// a sticky side-band and a sticky overflow indicator.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       SIDE_W   = 1,
  parameter int unsigned       DEPTH    = 1,
  parameter int unsigned       STALL_W  = STALL_W_DEF,
  parameter int unsigned       STAGE    = STAGE_ID,
  parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_PAYLOAD)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [STALL_W-1:0]         stall,
  input  logic                       flush,
  input  logic                       up_valid,
  input  logic [DATA_W-1:0]          up_data,
  input  logic [SIDE_W-1:0]          up_side,
  output logic                       up_ready,
  output logic                       dn_valid,
  output logic [DATA_W-1:0]          dn_data,
  output logic [SIDE_W-1:0]          dn_side,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf_err
);

  localparam int unsigned      PTR_W    = ptr_w(DEPTH);
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned      DN_STAGE = STAGE + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_c;
  logic              pop_c;
  logic              try_push_c;
  logic              stall_unused;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign stall_unused = ^stall;

  assign try_push_c = up_valid & (stall[STAGE] == NO_STOP);
  assign pop_c      = dn_valid & (stall[DN_STAGE] == NO_STOP);
  assign up_ready   = (count < CNT_FULL) | pop_c;
  assign push_c     = try_push_c & up_ready;

  // Head mux reads registered state only, so there is no up_* to dn_* path.
  assign dn_valid = (count != '0);
  assign dn_data  = dn_valid ? mem[rd_ptr] : NOP_DATA;

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dn_side <= '0;
      ovf_err <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dn_side <= '0;
    end else begin
      if (push_c) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        dn_side <= up_side;
      end
      if (pop_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push_c && !pop_c) begin
        count <= count + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count <= count - CNT_W'(1);
      end
      if (try_push_c && !up_ready) begin
        ovf_err <= 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!resetn && !flush && push_c) begin
      mem[wr_ptr] <= up_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH 1, 2 and 3 instances share stimulus and are each
// compared every cycle against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 144;
  localparam int unsigned NI = 3;
  localparam logic [DW-1:0] NOP = '0;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic [5:0]    stall;
  logic          up_valid;
  logic [DW-1:0] up_data;
  logic          up_side;

  logic [NI-1:0] rdy;
  logic [NI-1:0] dv;
  logic [NI-1:0] ds;
  logic [NI-1:0] ovf;
  logic [DW-1:0] dd  [NI];
  logic [2:0]    cnt [NI];

  logic [DW-1:0] mq [NI][$];
  logic          m_side [NI];
  logic          m_ovf  [NI];

  int  total = 0;
  int  bad   = 0;
  bit  armed = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(g + 2)-1:0] cnt_l;
    pipe_stage_buf #(.DEPTH(g + 1)) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .stall    (stall),
      .flush    (flush),
      .up_valid (up_valid),
      .up_data  (up_data),
      .up_side  (up_side),
      .up_ready (rdy[g]),
      .dn_valid (dv[g]),
      .dn_data  (dd[g]),
      .dn_side  (ds[g]),
      .count    (cnt_l),
      .ovf_err  (ovf[g])
    );
    assign cnt[g] = 3'(cnt_l);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input int i);
    bit can_pop;
    can_pop = (mq[i].size() != 0) && !stall[3];
    return (mq[i].size() < i + 1) || can_pop;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (resetn) begin
        mq[i].delete();
        m_side[i] = 1'b0;
        m_ovf[i]  = 1'b0;
      end else if (flush) begin
        mq[i].delete();
        m_side[i] = 1'b0;
      end else begin
        bit can_pop;
        bit ok;
        bit want;
        can_pop = (mq[i].size() != 0) && !stall[3];
        ok      = (mq[i].size() < i + 1) || can_pop;
        want    = up_valid && !stall[2];
        if (want && !ok) m_ovf[i] = 1'b1;
        if (can_pop) void'(mq[i].pop_front());
        if (want && ok) begin
          mq[i].push_back(up_data);
          m_side[i] = up_side;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    if (armed) begin
      for (int i = 0; i < NI; i++) check($sformatf("up_ready[%0d]", i), DW'(rdy[i]), DW'(model_ready(i)));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("dn_valid[%0d]", i), DW'(dv[i]), DW'(mq[i].size() != 0));
      check($sformatf("dn_data[%0d]", i), dd[i], (mq[i].size() != 0) ? mq[i][0] : NOP);
      check($sformatf("dn_side[%0d]", i), DW'(ds[i]), DW'(m_side[i]));
      check($sformatf("count[%0d]", i), DW'(cnt[i]), DW'(mq[i].size()));
      check($sformatf("ovf_err[%0d]", i), DW'(ovf[i]), DW'(m_ovf[i]));
    end
    armed = 1'b1;
  endtask

  task automatic drive(input logic rv, input logic fl, input logic [5:0] st,
                       input logic uv, input logic [DW-1:0] ud, input logic us);
    resetn   = rv;
    flush    = fl;
    stall    = st;
    up_valid = uv;
    up_data  = ud;
    up_side  = us;
    step();
  endtask

  function automatic logic [DW-1:0] rand_data();
    return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  initial begin
    logic [DW-1:0] a, b, c, d, e, f;
    logic [5:0] st;
    a = rand_data(); b = rand_data(); c = rand_data();
    d = rand_data(); e = rand_data(); f = rand_data();

    // Reset held two cycles with a valid upstream payload
    drive(1'b1, 1'b0, 6'b000000, 1'b1, a, 1'b1);
    drive(1'b1, 1'b0, 6'b000000, 1'b1, b, 1'b1);
    check("rst_dn_valid", DW'(dv[0]), '0);
    check("rst_dn_data", dd[0], NOP);
    check("rst_count", DW'(cnt[0]), '0);
    check("rst_dn_side", DW'(ds[0]), '0);

    // Single-entry flow, one cycle latency
    drive(1'b0, 1'b0, 6'b000000, 1'b1, a, 1'b1);
    check("flow_a", dd[0], a);
    drive(1'b0, 1'b0, 6'b000000, 1'b1, b, 1'b0);
    check("flow_b", dd[0], b);
    drive(1'b0, 1'b0, 6'b000000, 1'b1, c, 1'b1);
    check("flow_c", dd[0], c);

    // Bubble: upstream stalled, downstream runs
    drive(1'b0, 1'b0, 6'b000111, 1'b0, d, 1'b0);
    check("bubble_data", dd[0], NOP);
    check("bubble_side", DW'(ds[0]), DW'(1));

    // Elastic hold with downstream stalled
    drive(1'b0, 1'b0, 6'b001000, 1'b1, a, 1'b0);
    drive(1'b0, 1'b0, 6'b001000, 1'b1, b, 1'b1);
    drive(1'b0, 1'b0, 6'b001000, 1'b0, c, 1'b0);
    check("elastic_count", DW'(cnt[1]), DW'(2));
    check("elastic_ready", DW'(rdy[1]), '0);
    check("elastic_head_a", dd[1], a);
    drive(1'b0, 1'b0, 6'b000000, 1'b0, c, 1'b0);
    check("elastic_head_b", dd[1], b);
    drive(1'b0, 1'b0, 6'b000000, 1'b0, c, 1'b0);
    check("elastic_empty", DW'(dv[1]), '0);

    // Flush with two entries and a simultaneous push
    drive(1'b0, 1'b0, 6'b001000, 1'b1, d, 1'b1);
    drive(1'b0, 1'b0, 6'b001000, 1'b1, e, 1'b1);
    check("pre_flush_count", DW'(cnt[1]), DW'(2));
    drive(1'b0, 1'b1, 6'b001000, 1'b1, f, 1'b1);
    check("flush_count", DW'(cnt[1]), '0);
    check("flush_valid", DW'(dv[1]), '0);
    check("flush_side", DW'(ds[1]), '0);
    check("flush_ovf_clear", DW'(ovf[1]), '0);
    check("flush_ovf_kept", DW'(ovf[0]), DW'(1));

    // Overflow: full, downstream held, upstream pushing
    drive(1'b0, 1'b0, 6'b001000, 1'b1, a, 1'b0);
    drive(1'b0, 1'b0, 6'b001000, 1'b1, b, 1'b1);
    drive(1'b0, 1'b0, 6'b001000, 1'b1, c, 1'b0);
    check("ovf_set", DW'(ovf[1]), DW'(1));
    check("ovf_count", DW'(cnt[1]), DW'(2));
    check("ovf_head", dd[1], a);
    check("ovf_side", DW'(ds[1]), DW'(1));
    check("ovf_depth3_ok", DW'(ovf[2]), '0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 6'b000000, 1'b0, d, 1'b0);

    drive(1'b1, 1'b0, 6'b000000, 1'b0, d, 1'b0);
    check("rst_ovf_clear", DW'(ovf[1]), '0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      st = '0;
      for (int s = 0; s < 6; s++) st[s] = ($urandom_range(0, 9) < 3);
      drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0), st,
            ($urandom_range(0, 3) != 0), rand_data(), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
